// File: rtl/cflog_write_ctrl_pkg.sv
// Shared types and constants for the control-flow log write controller.
package cflog_write_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitDst,
    StWrSrc,
    StWrDst,
    StFull
  } state_e;

  // One log entry is two 16-bit words: source pc then destination pc.
  localparam logic [15:0] EntryBytes = 16'd4;
  localparam logic [15:0] WordStep   = 16'd2;

endpackage

// File: rtl/cflog_pend_q.sv
// One-deep branch event queue with a sticky overflow flag.
module cflog_pend_q (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] src_i,
  output logic        valid_o,
  output logic [15:0] src_o,
  output logic        ovf_o
);

  logic        valid_q, valid_d;
  logic [15:0] src_q, src_d;
  logic        ovf_q, ovf_d;

  // Pop frees the slot in the same cycle, so a simultaneous push is accepted.
  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    ovf_d   = ovf_q;
    if (pop_i) valid_d = 1'b0;
    if (push_i) begin
      if (valid_q && !pop_i) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        src_d   = src_i;
      end
    end
  end

  // Queue state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      src_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign src_o   = src_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/cflog_write_ctrl.sv
// Writes (source pc, destination pc) entries for each detected branch into the
// log RAM and requests a flush from the TCB when the region is full.
module cflog_write_ctrl
  import cflog_write_ctrl_pkg::*;
#(
  parameter logic [15:0] LOG_BASE = 16'h4000,
  parameter logic [15:0] LOG_SIZE = 16'h0040
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        inst_fetch,
  input  logic        branch_detect,
  input  logic        log_ack,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wr_data,
  output logic [15:0] log_ptr,
  output logic        flush_req,
  output logic        log_ovf
);

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] log_ptr_q, log_ptr_d;
  logic [15:0] ptr_next;

  logic        pend_push, pend_pop, pend_v, pend_ovf;
  logic [15:0] pend_src;

  // Events go to the queue unless IDLE can take them directly this cycle.
  always_comb begin
    pend_pop  = (state_q == StIdle) && pend_v;
    pend_push = branch_detect && ((state_q != StIdle) || pend_v);
  end

  cflog_pend_q u_pend_q (
    .clk_i   (clk),
    .rst_i   (puc_rst),
    .push_i  (pend_push),
    .pop_i   (pend_pop),
    .src_i   (pc),
    .valid_o (pend_v),
    .src_o   (pend_src),
    .ovf_o   (pend_ovf)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      log_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      log_ptr_q <= log_ptr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    log_ptr_d = log_ptr_q;
    ptr_next  = log_ptr_q + EntryBytes;
    unique case (state_q)
      StIdle: begin
        if (pend_v) begin
          src_d   = pend_src;
          state_d = StWaitDst;
        end else if (branch_detect) begin
          src_d   = pc;
          state_d = StWaitDst;
        end
      end
      StWaitDst: begin
        if (inst_fetch) begin
          dst_d   = pc;
          state_d = StWrSrc;
        end
      end
      StWrSrc: state_d = StWrDst;
      StWrDst: begin
        log_ptr_d = ptr_next;
        state_d   = (ptr_next >= LOG_SIZE) ? StFull : StIdle;
      end
      StFull: begin
        if (log_ack) begin
          log_ptr_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; everything is forced low during reset so an aborted write never strobes.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    flush_req   = 1'b0;
    log_ptr     = '0;
    log_ovf     = 1'b0;
    if (!puc_rst) begin
      log_ptr = log_ptr_q;
      log_ovf = pend_ovf;
      unique case (state_q)
        StWrSrc: begin
          mem_wr_en   = 1'b1;
          mem_addr    = LOG_BASE + log_ptr_q;
          mem_wr_data = src_q;
        end
        StWrDst: begin
          mem_wr_en   = 1'b1;
          mem_addr    = LOG_BASE + log_ptr_q + WordStep;
          mem_wr_data = dst_q;
        end
        StFull:  flush_req = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cflog_write_ctrl.sv
// Bench for cflog_write_ctrl: directed vector table plus randomized traffic
// checked against a queue-based event model.
module tb_cflog_write_ctrl;

  localparam logic [15:0] Base = 16'h4000;
  localparam logic [15:0] Size = 16'h0008;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] ptr;
    logic        flush;
    logic        ovf;
  } out_t;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        fetch;
    logic        det;
    logic        ack;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [15:0] pc = '0;
  logic        inst_fetch = 1'b0;
  logic        branch_detect = 1'b0;
  logic        log_ack = 1'b0;
  logic        mem_wr_en;
  logic [15:0] mem_addr, mem_wr_data, log_ptr;
  logic        flush_req, log_ovf;

  int checks = 0;
  int errors = 0;

  cflog_write_ctrl #(
    .LOG_BASE (Base),
    .LOG_SIZE (Size)
  ) dut (
    .clk           (clk),
    .puc_rst       (puc_rst),
    .pc            (pc),
    .inst_fetch    (inst_fetch),
    .branch_detect (branch_detect),
    .log_ack       (log_ack),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .log_ptr       (log_ptr),
    .flush_req     (flush_req),
    .log_ovf       (log_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: one active entry, a bounded pending queue, write phase count.
  bit          m_have = 0;
  bit          m_full = 0;
  bit          m_ovf  = 0;
  int          m_wr   = 0;  // 0 no write, 1 source word, 2 destination word
  int          m_ptr  = 0;
  logic [15:0] m_src  = '0;
  logic [15:0] m_dst  = '0;
  logic [15:0] pq[$];

  function automatic out_t model_out(input logic rst);
    out_t o;
    o = '0;
    if (rst) return o;
    o.wr    = (m_wr != 0);
    o.addr  = (m_wr == 0) ? 16'h0 : Base + 16'(m_ptr) + ((m_wr == 2) ? 16'd2 : 16'd0);
    o.data  = (m_wr == 1) ? m_src : (m_wr == 2) ? m_dst : 16'h0;
    o.flush = m_full;
    o.ptr   = 16'(m_ptr);
    o.ovf   = m_ovf;
    return o;
  endfunction

  task automatic model_step(input logic rst, input logic [15:0] p, input logic f,
                            input logic d, input logic a);
    bit idle, was_full;
    if (rst) begin
      m_have = 0; m_full = 0; m_ovf = 0; m_wr = 0; m_ptr = 0;
      m_src = '0; m_dst = '0; pq.delete();
      return;
    end
    idle     = !m_have && !m_full;
    was_full = m_full;
    if (m_wr == 2) begin
      m_ptr  += 4;
      m_have = 0;
      m_wr   = 0;
      if (m_ptr == int'(Size)) m_full = 1;
    end else if (m_wr == 1) begin
      m_wr = 2;
    end else if (m_have && f) begin
      m_dst = p;
      m_wr  = 1;
    end
    if (was_full && a) begin
      m_ptr  = 0;
      m_full = 0;
    end
    if (idle) begin
      if (pq.size() > 0) begin
        m_src  = pq.pop_front();
        m_have = 1;
        if (d) pq.push_back(p);
      end else if (d) begin
        m_src  = p;
        m_have = 1;
      end
    end else if (d) begin
      if (pq.size() == 0) pq.push_back(p);
      else m_ovf = 1;
    end
  endtask

  task automatic compare(input string name, input out_t act, input out_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t act wr=%b addr=%h data=%h ptr=%h flush=%b ovf=%b req wr=%b addr=%h data=%h ptr=%h flush=%b ovf=%b",
               name, $time, act.wr, act.addr, act.data, act.ptr, act.flush, act.ovf,
               req.wr, req.addr, req.data, req.ptr, req.flush, req.ovf);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] p, input logic f, input logic d,
                      input logic a, input bit has_exp, input out_t e, input string name);
    out_t act;
    puc_rst = r; pc = p; inst_fetch = f; branch_detect = d; log_ack = a;
    @(negedge clk);
    act = {mem_wr_en, mem_addr, mem_wr_data, log_ptr, flush_req, log_ovf};
    compare("model", act, model_out(r));
    if (has_exp) compare(name, act, e);
    model_step(r, p, f, d, a);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic r, input logic [15:0] p, input logic f,
                               input logic d, input logic a, input logic wr,
                               input logic [15:0] addr, input logic [15:0] data,
                               input logic [15:0] ptr, input logic fl, input logic ov);
    vec_t v;
    v.rst = r; v.pc = p; v.fetch = f; v.det = d; v.ack = a;
    v.exp = '{wr: wr, addr: addr, data: data, ptr: ptr, flush: fl, ovf: ov};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //                 rst pc       f  d  a   wr addr     data     ptr fl ov
    tbl.push_back(mkv(1, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0)); // reset
    tbl.push_back(mkv(0, 16'hE010, 0, 0 | 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'hE050, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'hE080, 1, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4000, 16'hE010, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4002, 16'hE080, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    // self-loop entry
    tbl.push_back(mkv(0, 16'hE020, 0, 1, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'hE020, 1, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4004, 16'hE020, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4006, 16'hE020, 4, 0, 0));
    // full: three detects, first kept, rest dropped
    tbl.push_back(mkv(0, 16'hE300, 0, 1, 0,  0, 16'h0000, 16'h0000, 8, 1, 0));
    tbl.push_back(mkv(0, 16'hE310, 0, 1, 0,  0, 16'h0000, 16'h0000, 8, 1, 0));
    tbl.push_back(mkv(0, 16'hE320, 0, 1, 0,  0, 16'h0000, 16'h0000, 8, 1, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 1,  0, 16'h0000, 16'h0000, 8, 1, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mkv(0, 16'hE400, 1, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4000, 16'hE300, 0, 0, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4002, 16'hE400, 0, 0, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 1));
    // reset during the destination write
    tbl.push_back(mkv(0, 16'hE500, 0, 1, 0,  0, 16'h0000, 16'h0000, 4, 0, 1));
    tbl.push_back(mkv(0, 16'hE510, 1, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 1));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4004, 16'hE500, 4, 0, 1));
    tbl.push_back(mkv(1, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    // detect during the source write goes pending
    tbl.push_back(mkv(0, 16'hE010, 0, 1, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'hE020, 1, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'hE100, 0, 1, 0,  1, 16'h4000, 16'hE010, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4002, 16'hE020, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'hE200, 1, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4004, 16'hE100, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4006, 16'hE200, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 8, 1, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 1,  0, 16'h0000, 16'h0000, 8, 1, 0));
    // ack outside FULL is ignored
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    // fetch and detect together while waiting for the destination
    tbl.push_back(mkv(0, 16'hE600, 0, 1, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'hE610, 1, 1, 0,  0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4000, 16'hE600, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4002, 16'hE610, 0, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'hE620, 1, 0, 0,  0, 16'h0000, 16'h0000, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4004, 16'hE610, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  1, 16'h4006, 16'hE620, 4, 0, 0));
    tbl.push_back(mkv(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 16'h0000, 8, 1, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].pc, tbl[i].fetch, tbl[i].det, tbl[i].ack, 1'b1, tbl[i].exp,
           $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), 16'($urandom()),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), 1'b0, '0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
